// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among NREQ byte streams, round-robin per message,
// paced against tx_busy, with a mid-message gap timeout that revokes a stalled grant.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int GAP_TIMEOUT = 1024,
  parameter int IDXW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              grant_valid,
  output logic [IDXW-1:0]   grant_idx,
  output logic              msg_abort
);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
  state_t state, state_nxt;
  logic [IDXW-1:0] ptr, pick, cand;
  logic [15:0] gap;
  logic last_q, any, fire, tout;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      msg_abort   <= 1'b0;
      ptr         <= IDXW'(NREQ - 1);
      gap         <= '0;
      last_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      msg_abort <= tout;
      if (state == IDLE && any) begin
        grant_idx   <= pick;
        grant_valid <= 1'b1;
      end
      if (tout || (state == HOLD && last_q)) begin
        ptr         <= grant_idx;
        grant_valid <= 1'b0;
      end
      // only a missing byte counts as a gap; a busy UART holds the count
      gap <= (state != LOAD || fire) ? '0 : gap + 16'(!req_valid[grant_idx]);
      if (fire) last_q <= req_last[grant_idx];
    end
  end

  always_comb begin
    pick = '0;
    cand = '0;
    any  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDXW'((int'(ptr) + k) % NREQ);
      if (req_valid[cand]) begin
        pick = cand;
        any  = 1'b1;
      end
    end
    tout = state == LOAD && !req_valid[grant_idx] && GAP_TIMEOUT != 0 && gap == 16'(GAP_TIMEOUT - 1);
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = LOAD;
      LOAD:    if (fire) state_nxt = HOLD; else if (tout) state_nxt = IDLE;
      HOLD:    state_nxt = last_q ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fire      = state == LOAD && req_valid[grant_idx] && !tx_busy;
    tx_start  = fire;
    tx_data   = fire ? req_data[{grant_idx, 3'b000} +: 8] : 8'd0;
    req_ready = fire ? NREQ'(1) << grant_idx : '0;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed requester streams with a scoreboard of expected (index, byte) pairs.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int IDXW = 2;
  logic clk = 1'b0, nrst = 1'b0, tx_busy;
  logic [NREQ-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [8*NREQ-1:0] req_data = '0;
  logic [7:0] tx_data;
  logic tx_start, grant_valid, msg_abort;
  logic [IDXW-1:0] grant_idx;
  logic [8:0] q[NREQ][$];
  int exp_q[$];
  int total = 0, bad = 0, cyc = 0, fire_cyc = 0, abort_cyc = 0, abort_cnt = 0;
  int busy_len = 20, busy_cnt = 0, f = 0, rel = 0;
  logic force_busy = 1'b0, prev_start = 1'b0;
  logic [NREQ-1:0] took = '0;

  uart_tx_arbiter #(.NREQ(NREQ), .GAP_TIMEOUT(8)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .msg_abort(msg_abort)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy rises the cycle after a start and lasts busy_len cycles
  always @(posedge clk)
    if (!nrst) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  assign tx_busy = busy_cnt != 0 || force_busy;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // requesters: drop an accepted byte, then present the head of each queue
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (took[i] && q[i].size() != 0) void'(q[i].pop_front());
      req_valid[i] = q[i].size() != 0;
      req_last[i] = q[i].size() != 0 ? q[i][0][8] : 1'b0;
      req_data[8*i +: 8] = q[i].size() != 0 ? q[i][0][7:0] : 8'd0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    took = req_ready;
    if (tx_start) begin
      check("busy_at_start", int'(tx_busy), 0);
      check("double_start", int'(prev_start), 0);
      check("ready_onehot", int'(req_ready), 1 << grant_idx);
      if (exp_q.size() == 0) check("unexpected_byte", int'(grant_idx) * 256 + int'(tx_data), -1);
      else check("byte", int'(grant_idx) * 256 + int'(tx_data), exp_q.pop_front());
      fire_cyc = cyc;
    end else begin
      check("idle_data", int'(tx_data), 0);
      check("idle_ready", int'(req_ready), 0);
    end
    if (msg_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
      check("abort_drops_grant", int'(grant_valid), 0);
    end
    prev_start = tx_start;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_empty(input string name);
    for (int n = 0; exp_q.size() != 0; n++) begin
      if (n == 600) begin
        check({name, "_timeout"}, exp_q.size(), 0);
        exp_q.delete();
        return;
      end
      tick(1);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick(2);
    nrst = 1'b1;
  endtask

  task automatic check_reset(input string name);
    check({name, "_gv"}, int'(grant_valid), 0);
    check({name, "_gi"}, int'(grant_idx), 0);
    check({name, "_abort"}, int'(msg_abort), 0);
    check({name, "_start"}, int'(tx_start), 0);
    check({name, "_ready"}, int'(req_ready), 0);
    check({name, "_data"}, int'(tx_data), 0);
  endtask

  initial begin
    tick(3);
    check_reset("rst");
    nrst = 1'b1;
    tick(1);

    // single message under a slow UART
    q[2].push_back({1'b0, 8'h41}); q[2].push_back({1'b1, 8'h42});
    exp_q.push_back(2 * 256 + 'h41); exp_q.push_back(2 * 256 + 'h42);
    wait_empty("single");
    check("hold_gv", int'(grant_valid), 1);
    tick(1);
    check("release_gv", int'(grant_valid), 0);
    check("no_abort_busy", abort_cnt, 0);
    tick(3);

    // four simultaneous messages go out in order 0..3
    busy_len = 3;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      q[i].push_back({1'b0, 8'(16 * (i + 1))}); q[i].push_back({1'b1, 8'(16 * (i + 1) + 1)});
      exp_q.push_back(i * 256 + 16 * (i + 1)); exp_q.push_back(i * 256 + 16 * (i + 1) + 1);
    end
    wait_empty("all4");
    tick(3);

    // requester 3 arrives mid-message and cuts in ahead of requester 1
    do_reset();
    q[1].push_back({1'b0, 8'hA0}); q[1].push_back({1'b0, 8'hA1}); q[1].push_back({1'b1, 8'hA2});
    q[1].push_back({1'b0, 8'hB0}); q[1].push_back({1'b1, 8'hB1}); q[1].push_back({1'b1, 8'hC0});
    exp_q = '{256 + 'hA0, 256 + 'hA1, 256 + 'hA2, 3 * 256 + 'hD0, 3 * 256 + 'hD1,
              256 + 'hB0, 256 + 'hB1, 256 + 'hC0};
    for (int n = 0; n < 100 && exp_q.size() == 8; n++) tick(1);
    q[3].push_back({1'b0, 8'hD0}); q[3].push_back({1'b1, 8'hD1});
    wait_empty("rr");
    tick(3);

    // gap timeout after a non-last byte
    do_reset();
    q[0].push_back({1'b0, 8'h55});
    q[1].push_back({1'b1, 8'h66});
    exp_q.push_back('h55); exp_q.push_back(256 + 'h66);
    for (int n = 0; n < 100 && exp_q.size() == 2; n++) tick(1);
    f = fire_cyc;
    for (int n = 0; n < 50 && abort_cnt == 0; n++) tick(1);
    check("abort_latency", abort_cyc - f, 10);
    wait_empty("timeout");
    tick(3);
    check("abort_once", abort_cnt, 1);

    // UART busy for 100 cycles with a byte waiting
    do_reset();
    force_busy = 1'b1;
    q[2].push_back({1'b1, 8'h77});
    exp_q.push_back(2 * 256 + 'h77);
    tick(100);
    check("busy_hold", exp_q.size(), 1);
    check("busy_gi", int'(grant_idx), 2);
    check("busy_no_abort", abort_cnt, 1);
    rel = cyc;
    force_busy = 1'b0;
    wait_empty("busy");
    check("busy_first_free", fire_cyc, rel + 1);
    tick(3);

    // reset in HOLD mid-message; pointer must restart at requester 0
    do_reset();
    q[1].push_back({1'b1, 8'h19});
    exp_q.push_back(256 + 'h19);
    wait_empty("pre");
    tick(4);
    q[3].push_back({1'b0, 8'h31}); q[3].push_back({1'b1, 8'h32});
    exp_q.push_back(3 * 256 + 'h31);
    wait_empty("mid");
    check("mid_gv", int'(grant_valid), 1);
    nrst = 1'b0;
    q[3].delete();
    tick(1);
    check_reset("midrst");
    nrst = 1'b1;
    q[1].push_back({1'b1, 8'h11}); q[2].push_back({1'b1, 8'h22});
    exp_q.push_back(256 + 'h11); exp_q.push_back(2 * 256 + 'h22);
    wait_empty("after_rst");
    tick(3);
    check("final_abort_cnt", abort_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end
endmodule
